// File: rtl/uart_rx_pkg.sv
// Shared UART RX/TX definitions: parity modes, receiver FSM states and
// the expected-parity helper used by both the checker and the TX generator.
package uart_rx_pkg;

    localparam logic [1:0] PAR_EVEN  = 2'd0;
    localparam logic [1:0] PAR_ODD   = 2'd1;
    localparam logic [1:0] PAR_MARK  = 2'd2;
    localparam logic [1:0] PAR_SPACE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

    // Parity bit a correct frame carries, given the XOR of its data bits.
    function automatic logic expected_parity(input logic [1:0] mode, input logic data_xor);
        case (mode)
            PAR_EVEN: return data_xor;
            PAR_ODD:  return ~data_xor;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_frame_checker_if.sv
// Bit-strobe input side and frame-report output side of the RX frame checker.
interface uart_rx_frame_checker_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 8
);
    logic                     PAR_EN;
    logic [1:0]               PAR_MODE;
    logic                     sample_valid;
    logic                     sampled_data;
    logic                     clr_err_cnt;
    logic [DATA_WIDTH-1:0]    data_out;
    logic                     frame_done;
    logic                     parity_err;
    logic                     stop_err;
    logic                     busy;
    logic [ERR_CNT_WIDTH-1:0] err_count;

    // Sampler / register-interface side.
    modport master (
        output PAR_EN, PAR_MODE, sample_valid, sampled_data, clr_err_cnt,
        input  data_out, frame_done, parity_err, stop_err, busy, err_count
    );

    // Frame checker side.
    modport slave (
        input  PAR_EN, PAR_MODE, sample_valid, sampled_data, clr_err_cnt,
        output data_out, frame_done, parity_err, stop_err, busy, err_count
    );
endinterface

// File: rtl/uart_rx_frame_checker_sat_counter.sv
// Saturating up-counter; clear takes priority over increment.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear first, otherwise step unless already at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (srst) count_q <= '0;
        else      count_q <= count_d;
    end

    assign count_o = count_q;
endmodule

// File: rtl/uart_rx_frame_checker.sv
// UART receive frame checker: deserialises DATA_WIDTH bits LSB-first from
// sampled bit strobes, checks parity and stop bits, reports each frame.
module uart_rx_frame_checker
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int STOP_BITS     = 1,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    uart_rx_frame_checker_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    rx_state_e             state_q;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  acc_q;
    logic                  par_en_q;
    logic [1:0]            par_mode_q;
    logic                  par_mis_q;
    logic                  stop_run_q;
    logic                  stop_cnt_q;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  frame_done_q;
    logic                  parity_err_q;
    logic                  stop_err_q;
    logic                  err_inc;
    logic [ERR_CNT_WIDTH-1:0] err_count_w;

    // Frame FSM: advances only on bit strobes; frame results are registered here.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            acc_q        <= 1'b0;
            par_en_q     <= 1'b0;
            par_mode_q   <= PAR_EVEN;
            par_mis_q    <= 1'b0;
            stop_run_q   <= 1'b0;
            stop_cnt_q   <= 1'b0;
            data_out_q   <= '0;
            frame_done_q <= 1'b0;
            parity_err_q <= 1'b0;
            stop_err_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (bus.sample_valid) begin
                case (state_q)
                    ST_IDLE: begin
                        // A low line bit is the start bit; parity setup is frozen here.
                        if (!bus.sampled_data) begin
                            par_en_q   <= bus.PAR_EN;
                            par_mode_q <= bus.PAR_MODE;
                            bit_cnt_q  <= '0;
                            acc_q      <= 1'b0;
                            par_mis_q  <= 1'b0;
                            stop_run_q <= 1'b0;
                            stop_cnt_q <= 1'b0;
                            state_q    <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        shift_q   <= {bus.sampled_data, shift_q[DATA_WIDTH-1:1]};
                        acc_q     <= acc_q ^ bus.sampled_data;
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= par_en_q ? ST_PARITY : ST_STOP;
                        end
                    end
                    ST_PARITY: begin
                        par_mis_q <= par_en_q &
                                     (bus.sampled_data != expected_parity(par_mode_q, acc_q));
                        state_q   <= ST_STOP;
                    end
                    ST_STOP: begin
                        // A bad stop bit is flagged but the word is still delivered.
                        if (stop_cnt_q == LAST_STOP) begin
                            data_out_q   <= shift_q;
                            parity_err_q <= par_mis_q;
                            stop_err_q   <= stop_run_q | ~bus.sampled_data;
                            frame_done_q <= 1'b1;
                            state_q      <= ST_IDLE;
                        end else begin
                            stop_run_q <= stop_run_q | ~bus.sampled_data;
                            stop_cnt_q <= stop_cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign err_inc = frame_done_q & (parity_err_q | stop_err_q);

    sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_err_cnt (
        .clk     (CLK),
        .srst    (RST),
        .inc_i   (err_inc),
        .clr_i   (bus.clr_err_cnt),
        .count_o (err_count_w)
    );

    assign bus.data_out   = data_out_q;
    assign bus.frame_done = frame_done_q;
    assign bus.parity_err = parity_err_q;
    assign bus.stop_err   = stop_err_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.err_count  = err_count_w;
endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// Directed bench for uart_rx_frame_checker: instance A (8 data, 1 stop,
// 8-bit counter) and instance B (7 data, 2 stop, 2-bit counter).
module tb_uart_rx_frame_checker;
    import uart_rx_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   fd_a = 0;
    int   fd_b = 0;

    always #5 clk = ~clk;

    uart_rx_frame_checker_if #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(8)) ifa ();
    uart_rx_frame_checker_if #(.DATA_WIDTH(7), .ERR_CNT_WIDTH(2)) ifb ();

    uart_rx_frame_checker #(.DATA_WIDTH(8), .STOP_BITS(1), .ERR_CNT_WIDTH(8)) dut_a (
        .CLK (clk), .RST (rst), .bus (ifa)
    );
    uart_rx_frame_checker #(.DATA_WIDTH(7), .STOP_BITS(2), .ERR_CNT_WIDTH(2)) dut_b (
        .CLK (clk), .RST (rst), .bus (ifb)
    );

    // Count frame_done pulses per instance.
    always @(posedge clk) begin
        if (ifa.frame_done) fd_a <= fd_a + 1;
        if (ifb.frame_done) fd_b <= fd_b + 1;
    end

    typedef struct {
        logic       par_en;
        logic [1:0] mode;
        logic [8:0] data;
        logic       par_bit;
        logic       stop_bit;
        logic [8:0] exp_data;
        logic       exp_pe;
        logic       exp_se;
        int         exp_cnt;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic drive_bit(input int sel, input logic b);
        @(negedge clk);
        if (sel == 0) begin
            ifa.sample_valid = 1'b1;
            ifa.sampled_data = b;
        end else begin
            ifb.sample_valid = 1'b1;
            ifb.sampled_data = b;
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        ifa.sample_valid = 1'b0;
        ifb.sample_valid = 1'b0;
        ifa.sampled_data = 1'b1;
        ifb.sampled_data = 1'b1;
    endtask

    // Back-to-back strobes for one frame; with do_idle the task returns in the
    // cycle where frame_done is visible.
    task automatic send_frame(input int sel, input int width, input logic par_en,
                              input logic [8:0] data, input logic par_bit,
                              input logic stop0, input logic stop1, input int nstop,
                              input bit do_idle);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < width; i++) drive_bit(sel, data[i]);
        if (par_en) drive_bit(sel, par_bit);
        drive_bit(sel, stop0);
        if (nstop == 2) drive_bit(sel, stop1);
        if (do_idle) idle_cycle();
    endtask

    initial begin
        int fd_before;

        ifa.PAR_EN = 1'b0; ifa.PAR_MODE = PAR_EVEN; ifa.sample_valid = 1'b0;
        ifa.sampled_data = 1'b1; ifa.clr_err_cnt = 1'b0;
        ifb.PAR_EN = 1'b0; ifb.PAR_MODE = PAR_EVEN; ifb.sample_valid = 1'b0;
        ifb.sampled_data = 1'b1; ifb.clr_err_cnt = 1'b0;

        //            par_en mode       data    pbit stop  exp_data pe    se    cnt
        vecs[0] = '{1'b1, PAR_EVEN,  9'h0B3, 1'b1, 1'b1, 9'h0B3, 1'b0, 1'b0, 0};
        vecs[1] = '{1'b1, PAR_ODD,   9'h0B3, 1'b1, 1'b1, 9'h0B3, 1'b1, 1'b0, 1};
        vecs[2] = '{1'b1, PAR_MARK,  9'h000, 1'b1, 1'b1, 9'h000, 1'b0, 1'b0, 1};
        vecs[3] = '{1'b1, PAR_SPACE, 9'h000, 1'b1, 1'b1, 9'h000, 1'b1, 1'b0, 2};
        vecs[4] = '{1'b0, PAR_EVEN,  9'h05A, 1'b0, 1'b1, 9'h05A, 1'b0, 1'b0, 2};
        vecs[5] = '{1'b1, PAR_EVEN,  9'h00F, 1'b0, 1'b0, 9'h00F, 1'b0, 1'b1, 3};
        vecs[6] = '{1'b1, PAR_EVEN,  9'h0FF, 1'b0, 1'b1, 9'h0FF, 1'b0, 1'b0, 3};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_a_data", 32'(ifa.data_out), 0);
        chk("rst_a_done", 32'(ifa.frame_done), 0);
        chk("rst_a_perr", 32'(ifa.parity_err), 0);
        chk("rst_a_serr", 32'(ifa.stop_err), 0);
        chk("rst_a_busy", 32'(ifa.busy), 0);
        chk("rst_a_cnt", 32'(ifa.err_count), 0);
        chk("rst_b_busy", 32'(ifb.busy), 0);
        chk("rst_b_cnt", 32'(ifb.err_count), 0);

        // Table-driven frames on instance A.
        for (int v = 0; v < 7; v++) begin
            ifa.PAR_EN   = vecs[v].par_en;
            ifa.PAR_MODE = vecs[v].mode;
            fd_before    = fd_a;
            send_frame(0, 8, vecs[v].par_en, vecs[v].data, vecs[v].par_bit,
                       vecs[v].stop_bit, 1'b1, 1, 1'b1);
            chk($sformatf("v%0d_done", v), 32'(ifa.frame_done), 1);
            chk($sformatf("v%0d_data", v), 32'(ifa.data_out), 32'(vecs[v].exp_data));
            chk($sformatf("v%0d_perr", v), 32'(ifa.parity_err), 32'(vecs[v].exp_pe));
            chk($sformatf("v%0d_serr", v), 32'(ifa.stop_err), 32'(vecs[v].exp_se));
            chk($sformatf("v%0d_busy", v), 32'(ifa.busy), 0);
            idle_cycle();
            chk($sformatf("v%0d_pulses", v), 32'(fd_a - fd_before), 1);
            chk($sformatf("v%0d_done_low", v), 32'(ifa.frame_done), 0);
            chk($sformatf("v%0d_cnt", v), 32'(ifa.err_count), 32'(vecs[v].exp_cnt));
        end

        // Mode changed to odd mid-frame: the even mode latched at start applies.
        ifa.PAR_EN = 1'b1; ifa.PAR_MODE = PAR_EVEN;
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        chk("mid_busy", 32'(ifa.busy), 1);
        ifa.PAR_MODE = PAR_ODD;
        ifa.PAR_EN   = 1'b0;
        for (int i = 1; i < 8; i++) drive_bit(0, (i == 1 || i == 4 || i == 5 || i == 7));
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);
        idle_cycle();
        chk("mid_done", 32'(ifa.frame_done), 1);
        chk("mid_data", 32'(ifa.data_out), 32'h0B3);
        chk("mid_perr", 32'(ifa.parity_err), 0);
        idle_cycle();
        chk("mid_cnt", 32'(ifa.err_count), 3);

        // Start bit immediately after the previous stop bit.
        ifa.PAR_EN = 1'b1; ifa.PAR_MODE = PAR_EVEN;
        fd_before = fd_a;
        send_frame(0, 8, 1'b1, 9'h012, 1'b0, 1'b1, 1'b1, 1, 1'b0);
        send_frame(0, 8, 1'b1, 9'h034, 1'b1, 1'b1, 1'b1, 1, 1'b1);
        chk("b2b_data", 32'(ifa.data_out), 32'h034);
        chk("b2b_perr", 32'(ifa.parity_err), 0);
        idle_cycle();
        chk("b2b_pulses", 32'(fd_a - fd_before), 2);

        // Reset after four data bits discards the partial frame.
        fd_before = fd_a;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, 1'b1);
        @(negedge clk);
        ifa.sample_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_data", 32'(ifa.data_out), 0);
        chk("mrst_busy", 32'(ifa.busy), 0);
        chk("mrst_cnt", 32'(ifa.err_count), 0);
        chk("mrst_no_done", 32'(fd_a - fd_before), 0);
        send_frame(0, 8, 1'b1, 9'h0B3, 1'b1, 1'b1, 1'b1, 1, 1'b1);
        chk("post_rst_data", 32'(ifa.data_out), 32'h0B3);
        chk("post_rst_perr", 32'(ifa.parity_err), 0);
        idle_cycle();
        chk("post_rst_pulses", 32'(fd_a - fd_before), 1);

        // Instance B: two stop bits, seven data bits, no parity.
        ifb.PAR_EN = 1'b0;
        send_frame(1, 7, 1'b0, 9'h055, 1'b0, 1'b1, 1'b0, 2, 1'b1);
        chk("b1_done", 32'(ifb.frame_done), 1);
        chk("b1_data", 32'(ifb.data_out), 32'h055);
        chk("b1_serr", 32'(ifb.stop_err), 1);
        chk("b1_perr", 32'(ifb.parity_err), 0);
        idle_cycle();
        chk("b1_cnt", 32'(ifb.err_count), 1);
        send_frame(1, 7, 1'b0, 9'h02A, 1'b0, 1'b0, 1'b1, 2, 1'b1);
        chk("b2_serr", 32'(ifb.stop_err), 1);
        chk("b2_data", 32'(ifb.data_out), 32'h02A);
        idle_cycle();
        chk("b2_cnt", 32'(ifb.err_count), 2);
        send_frame(1, 7, 1'b0, 9'h011, 1'b0, 1'b1, 1'b1, 2, 1'b1);
        chk("b3_serr", 32'(ifb.stop_err), 0);
        idle_cycle();
        chk("b3_cnt", 32'(ifb.err_count), 2);
        for (int k = 0; k < 3; k++) begin
            send_frame(1, 7, 1'b0, 9'h07F, 1'b0, 1'b0, 1'b0, 2, 1'b1);
            idle_cycle();
        end
        chk("sat_cnt", 32'(ifb.err_count), 3);

        @(negedge clk); ifb.clr_err_cnt = 1'b1;
        @(negedge clk); ifb.clr_err_cnt = 1'b0;
        chk("clr_cnt", 32'(ifb.err_count), 0);

        // Clear coincident with the increment of a bad frame.
        send_frame(1, 7, 1'b0, 9'h001, 1'b0, 1'b1, 1'b0, 2, 1'b1);
        ifb.clr_err_cnt = 1'b1;
        @(negedge clk); ifb.clr_err_cnt = 1'b0;
        chk("clr_wins_cnt", 32'(ifb.err_count), 0);
        send_frame(1, 7, 1'b0, 9'h001, 1'b0, 1'b0, 1'b1, 2, 1'b1);
        idle_cycle();
        chk("after_clr_cnt", 32'(ifb.err_count), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
